// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared regfile constants, command codes and sequencer state type
package regfile_pkg;

    localparam int INDEX_WIDTH = 3;
    localparam int COM_WIDTH   = 4;

    localparam logic [INDEX_WIDTH-1:0] RV = 3'd5;
    localparam logic [INDEX_WIDTH-1:0] SP = 3'd6;
    localparam logic [INDEX_WIDTH-1:0] F  = 3'd7;

    localparam logic [COM_WIDTH-1:0] COM_NOP      = 4'h0;
    localparam logic [COM_WIDTH-1:0] COM_READA    = 4'h1;
    localparam logic [COM_WIDTH-1:0] COM_READB    = 4'h2;
    localparam logic [COM_WIDTH-1:0] COM_LATCHC   = 4'h3;
    localparam logic [COM_WIDTH-1:0] COM_LATCHSEL = 4'h4;
    localparam logic [COM_WIDTH-1:0] COM_LATCHRV  = 4'h7;
    localparam logic [COM_WIDTH-1:0] COM_LATCHSP  = 4'h8;
    localparam logic [COM_WIDTH-1:0] COM_LATCHF   = 4'h9;

    typedef enum logic [3:0] {
        SEQ_IDLE,
        SEQ_SEL_A,
        SEQ_READ_A,
        SEQ_SEL_B,
        SEQ_READ_B,
        SEQ_EXEC,
        SEQ_SEL_C,
        SEQ_LATCH_C,
        SEQ_LATCH_F,
        SEQ_DONE,
        SEQ_ABORT
    } seq_state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - expands one ALU instruction into the regfile command stream
module regfile_sequencer #(
    parameter int INDEX_WIDTH = regfile_pkg::INDEX_WIDTH,
    parameter int COM_WIDTH   = regfile_pkg::COM_WIDTH,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [INDEX_WIDTH-1:0] i_rs1,
    input  logic [INDEX_WIDTH-1:0] i_rs2,
    input  logic [INDEX_WIDTH-1:0] i_rd,
    input  logic                   i_use_rs2,
    input  logic                   i_write_flags,
    output logic [COM_WIDTH-1:0]   o_com,
    output logic [INDEX_WIDTH-1:0] o_sel,
    output logic                   o_alu_start,
    input  logic                   i_alu_done,
    output logic                   o_done,
    output logic                   o_error
);
    import regfile_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [INDEX_WIDTH-1:0] rs1_q, rs1_d;
    logic [INDEX_WIDTH-1:0] rs2_q, rs2_d;
    logic [INDEX_WIDTH-1:0] rd_q, rd_d;
    logic                   use_rs2_q, use_rs2_d;
    logic                   wflags_q, wflags_d;
    logic                   rd_special;
    logic                   rd_is_f;

    assign rd_is_f    = (rd_q == INDEX_WIDTH'(F));
    assign rd_special = (rd_q == INDEX_WIDTH'(RV)) || (rd_q == INDEX_WIDTH'(SP)) || rd_is_f;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            cnt_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            use_rs2_q <= 1'b0;
            wflags_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            use_rs2_q <= use_rs2_d;
            wflags_q  <= wflags_d;
        end
    end

    // Counter sits at zero outside EXEC, so it is already cleared on every EXEC entry.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        use_rs2_d   = use_rs2_q;
        wflags_d    = wflags_q;
        o_ready     = 1'b0;
        o_com       = COM_WIDTH'(COM_NOP);
        o_sel       = '0;
        o_alu_start = 1'b0;
        o_done      = 1'b0;
        o_error     = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    rs1_d     = i_rs1;
                    rs2_d     = i_rs2;
                    rd_d      = i_rd;
                    use_rs2_d = i_use_rs2;
                    wflags_d  = i_write_flags;
                    state_d   = SEQ_SEL_A;
                end
            end
            SEQ_SEL_A: begin
                o_com   = COM_WIDTH'(COM_LATCHSEL);
                o_sel   = rs1_q;
                state_d = SEQ_READ_A;
            end
            SEQ_READ_A: begin
                o_com   = COM_WIDTH'(COM_READA);
                state_d = use_rs2_q ? SEQ_SEL_B : SEQ_EXEC;
            end
            SEQ_SEL_B: begin
                o_com   = COM_WIDTH'(COM_LATCHSEL);
                o_sel   = rs2_q;
                state_d = SEQ_READ_B;
            end
            SEQ_READ_B: begin
                o_com   = COM_WIDTH'(COM_READB);
                state_d = SEQ_EXEC;
            end
            SEQ_EXEC: begin
                o_alu_start = (cnt_q == '0);
                cnt_d       = cnt_q + 1'b1;
                if (i_alu_done) begin
                    state_d = rd_special ? SEQ_LATCH_C : SEQ_SEL_C;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = SEQ_ABORT;
                end
            end
            SEQ_SEL_C: begin
                o_com   = COM_WIDTH'(COM_LATCHSEL);
                o_sel   = rd_q;
                state_d = SEQ_LATCH_C;
            end
            SEQ_LATCH_C: begin
                if (rd_q == INDEX_WIDTH'(RV))      o_com = COM_WIDTH'(COM_LATCHRV);
                else if (rd_q == INDEX_WIDTH'(SP)) o_com = COM_WIDTH'(COM_LATCHSP);
                else if (rd_is_f)                  o_com = COM_WIDTH'(COM_LATCHF);
                else                               o_com = COM_WIDTH'(COM_LATCHC);
                // A result written to F already overwrites the flags; a second latch would clobber it.
                state_d = (wflags_q && !rd_is_f) ? SEQ_LATCH_F : SEQ_DONE;
            end
            SEQ_LATCH_F: begin
                o_com   = COM_WIDTH'(COM_LATCHF);
                state_d = SEQ_DONE;
            end
            SEQ_DONE: begin
                o_done  = 1'b1;
                state_d = SEQ_IDLE;
            end
            SEQ_ABORT: begin
                o_error = 1'b1;
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - directed and randomized checks of the command stream against a reference list
module tb_regfile_sequencer;

    localparam int TMO = 4;
    localparam int C_NOP = 0, C_RA = 1, C_RB = 2, C_LC = 3, C_SEL = 4, C_RV = 7, C_SP = 8, C_F = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [2:0] i_rs1 = '0, i_rs2 = '0, i_rd = '0;
    logic       i_use_rs2 = 1'b0, i_write_flags = 1'b0;
    logic [3:0] o_com;
    logic [2:0] o_sel;
    logic       o_alu_start;
    logic       i_alu_done = 1'b0;
    logic       o_done, o_error;

    int checks = 0;
    int failures = 0;

    regfile_sequencer #(.INDEX_WIDTH(3), .COM_WIDTH(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_use_rs2(i_use_rs2),
        .i_write_flags(i_write_flags), .o_com(o_com), .o_sel(o_sel),
        .o_alu_start(o_alu_start), .i_alu_done(i_alu_done),
        .o_done(o_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, o_ready, 1);
        chk({tag, "_com"}, o_com, C_NOP);
        chk({tag, "_sel"}, o_sel, 0);
        chk({tag, "_pulses"}, {o_alu_start, o_done, o_error}, 0);
    endtask

    // Expected per-cycle (command, select) list from acceptance+1 through the DONE/ABORT cycle.
    task automatic run_instr(input int rs1, input int rs2, input int rd, input bit use2,
                             input bit wf, input int dly, input bit hold);
        int  ecom[$], esel[$], ocom[$], osel[$];
        int  starts = 0, k = 0, n;
        bit  started = 0, tmo, got_end = 0, last_done = 0, last_err = 0;
        tmo = (dly >= TMO);
        ecom.push_back(C_SEL); esel.push_back(rs1);
        ecom.push_back(C_RA);  esel.push_back(0);
        if (use2) begin
            ecom.push_back(C_SEL); esel.push_back(rs2);
            ecom.push_back(C_RB);  esel.push_back(0);
        end
        n = tmo ? TMO : dly + 1;
        repeat (n) begin ecom.push_back(C_NOP); esel.push_back(0); end
        if (!tmo) begin
            if (rd == 5)      begin ecom.push_back(C_RV); esel.push_back(0); end
            else if (rd == 6) begin ecom.push_back(C_SP); esel.push_back(0); end
            else if (rd == 7) begin ecom.push_back(C_F);  esel.push_back(0); end
            else begin
                ecom.push_back(C_SEL); esel.push_back(rd);
                ecom.push_back(C_LC);  esel.push_back(0);
            end
            if (wf && rd != 7) begin ecom.push_back(C_F); esel.push_back(0); end
        end
        ecom.push_back(C_NOP); esel.push_back(0);

        @(negedge clk);
        chk("accept_ready", o_ready, 1);
        i_valid = 1'b1; i_rs1 = 3'(rs1); i_rs2 = 3'(rs2); i_rd = 3'(rd);
        i_use_rs2 = use2; i_write_flags = wf;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            ocom.push_back(int'(o_com)); osel.push_back(int'(o_sel));
            if (o_alu_start) begin starts++; started = 1; k = 0; end
            else if (started) k++;
            i_alu_done = started && (k == dly);
            if (hold) begin
                i_rs1 = 3'($urandom); i_rs2 = 3'($urandom); i_rd = 3'($urandom);
                i_use_rs2 = 1'($urandom); i_write_flags = 1'($urandom);
            end else begin
                i_valid = 1'b0;
            end
            if (o_done || o_error) begin
                got_end = 1; last_done = o_done; last_err = o_error;
                break;
            end
        end
        i_alu_done = 1'b0;
        chk("seq_finished", got_end, 1);
        chk("seq_length", ocom.size(), ecom.size());
        for (int i = 0; i < ecom.size() && i < ocom.size(); i++) begin
            chk($sformatf("com[%0d]", i), ocom[i], ecom[i]);
            chk($sformatf("sel[%0d]", i), osel[i], esel[i]);
        end
        chk("alu_starts", starts, 1);
        chk("done_pulse", last_done, !tmo);
        chk("error_pulse", last_err, tmo);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;

        run_instr(1, 2, 3, 1, 1, 2, 0);
        run_instr(4, 0, 6, 0, 0, 0, 0);
        run_instr(2, 3, 7, 1, 1, 1, 0);
        run_instr(0, 1, 5, 1, 1, 0, 0);
        run_instr(3, 5, 2, 1, 0, 1000, 0);
        run_instr(6, 4, 1, 0, 1, 3, 0);

        run_instr(5, 6, 4, 1, 1, 1, 1);
        run_instr(7, 1, 0, 1, 0, 0, 0);

        for (int t = 0; t < 10; t++) begin
            run_instr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      1'($urandom), 1'($urandom), $urandom_range(0, 5), 1'($urandom));
        end

        @(negedge clk);
        chk("rst_accept_ready", o_ready, 1);
        i_valid = 1'b1; i_rs1 = 3'd1; i_rs2 = 3'd2; i_rd = 3'd3;
        i_use_rs2 = 1'b1; i_write_flags = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_readb", o_com, C_RB);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("mid_reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("post_reset%0d", i));
        end
        run_instr(2, 7, 4, 1, 1, 1, 0);

        @(negedge clk);
        chk_idle("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
